// File: rtl/mix_columns_seq.sv
// AES MixColumns sequencer: shares LANES GF(2^8) row-by-column dot-product units
// across the 16 output bytes, with a single start/done handshake.

module multibly_col_by_row (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [7:0]  res_mul
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Only the 01/02/03 coefficients of the MixColumns matrix are supported.
    function automatic logic [7:0] gmul123(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        case (c)
            8'h01:   r = b;
            8'h02:   r = xtime(b);
            8'h03:   r = xtime(b) ^ b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        res_mul = gmul123(in1[31:24], in2[31:24]) ^
                  gmul123(in1[23:16], in2[23:16]) ^
                  gmul123(in1[15:8],  in2[15:8])  ^
                  gmul123(in1[7:0],   in2[7:0]);
    end

endmodule

module mix_columns_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
            $error("mix_columns_seq: LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [127:0]  work_in_q, work_in_d;
    logic [127:0]  work_out_q, work_out_d;
    logic [127:0]  state_out_q, state_out_d;

    logic [31:0]   col_word [4];
    logic [3:0]    lane_k   [LANES];
    logic [31:0]   lane_row [LANES];
    logic [31:0]   lane_col [LANES];
    logic [7:0]    lane_res [LANES];

    function automatic logic [31:0] coef_row(input logic [1:0] r);
        logic [31:0] w;
        case (r)
            2'd0:    w = 32'h02030101;
            2'd1:    w = 32'h01020301;
            2'd2:    w = 32'h01010203;
            default: w = 32'h03010102;
        endcase
        return w;
    endfunction

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            col_word[c] = work_in_q[127 - 32*c -: 32];
        end
    end

    // Lane j handles output byte idx+j: row picks the coefficients, column the state word.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_k[j]   = idx_q + 4'(j);
            lane_row[j] = coef_row(lane_k[j][1:0]);
            lane_col[j] = col_word[lane_k[j][3:2]];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        multibly_col_by_row u_dot (
            .in1     (lane_row[j]),
            .in2     (lane_col[j]),
            .res_mul (lane_res[j])
        );
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        work_in_d   = work_in_q;
        work_out_d  = work_out_q;
        state_out_d = state_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_in_d = state_in;
                    idx_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Byte k lives at bit offset 8*(15-k), i.e. {~k, 3'b000}.
                for (int j = 0; j < LANES; j++) begin
                    work_out_d[{~lane_k[j], 3'b000} +: 8] = lane_res[j];
                end
                idx_d = idx_q + 4'(LANES);
                if (idx_q == 4'(16 - LANES)) begin
                    state_d     = DONE;
                    state_out_d = work_out_d;
                end
            end
            DONE: begin
                if (start) begin
                    work_in_d = state_in;
                    idx_d     = '0;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            work_in_q   <= '0;
            work_out_q  <= '0;
            state_out_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            work_in_q   <= work_in_d;
            work_out_q  <= work_out_d;
            state_out_q <= state_out_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign state_out = state_out_q;

endmodule
